// File: rtl/mor1kx_dpram_be_sclk.sv
// Simple dual-port RAM with byte enables, read-during-write bypass,
// optional output register and a self-timed clear sequencer.
// Ports: clk, rst_n, clear, busy, raddr, re, waddr, we, wbe, din,
// dout, dout_valid.
module mor1kx_dpram_be_sclk #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ENABLE_BYPASS  = 1,
  parameter int OUTPUT_REG     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  output logic                    busy,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam bit AUTO  = (CLEAR_ON_RESET != 0);
  localparam bit BYP   = (ENABLE_BYPASS != 0);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [ADDR_WIDTH-1:0]   cnt_nxt;
  logic                    boot;
  logic                    wr_en;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rd_old;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [DATA_WIDTH-1:0]   d1;
  logic                    v1;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign busy  = (state == CLEAR);
  assign wr_en = we & ~busy;
  assign rd_en = re & ~busy;

  // boot is high only until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      boot  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      boot  <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if ((boot && AUTO) || clear)
          state_nxt = CLEAR;
      end
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else if (we) begin
      for (int i = 0; i < NB; i++)
        if (wbe[i])
          mem[waddr][8*i +: 8] <= din[8*i +: 8];
    end
  end

  // same-address bypass merges the written bytes over old data
  always_comb begin
    rd_old  = mem[raddr];
    rd_data = rd_old;
    if (BYP && wr_en && (waddr == raddr)) begin
      for (int i = 0; i < NB; i++)
        if (wbe[i])
          rd_data[8*i +: 8] = din[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd_en;
      if (rd_en)
        d1 <= rd_data;
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] d2;
      logic                  v2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1)
            d2 <= d1;
        end
      end
      assign dout       = d2;
      assign dout_valid = v2;
    end else begin : g_noreg
      assign dout       = d1;
      assign dout_valid = v1;
    end
  endgenerate

endmodule

// File: tb/tb_mor1kx_dpram_be_sclk.sv
// Randomized bench for mor1kx_dpram_be_sclk with a behavioural model.
// Two instances: bypass/latency-1 and no-bypass/latency-2.
module tb_mor1kx_dpram_be_sclk;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  raddr = '0;
  logic        re = 1'b0;
  logic [3:0]  waddr = '0;
  logic        we = 1'b0;
  logic [3:0]  wbe = '0;
  logic [31:0] din = '0;

  logic        busy0, busy1;
  logic [31:0] dout0, dout1;
  logic        val0, val1;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  mor1kx_dpram_be_sclk #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .ENABLE_BYPASS(1),
    .OUTPUT_REG(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy0),
    .raddr(raddr), .re(re), .waddr(waddr), .we(we),
    .wbe(wbe), .din(din), .dout(dout0), .dout_valid(val0)
  );

  mor1kx_dpram_be_sclk #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .ENABLE_BYPASS(0),
    .OUTPUT_REG(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy1),
    .raddr(raddr), .re(re), .waddr(waddr), .we(we),
    .wbe(wbe), .din(din), .dout(dout1), .dout_valid(val1)
  );

  // reference model state
  logic [31:0] mem_m [16];
  int          busy_rem = 0;
  bit          boot = 1'b1;
  bit          s1v = 1'b0;
  logic [31:0] s1d = '0;
  bit          exp_busy = 1'b0;
  bit          e0v = 1'b0, e1v = 1'b0;
  logic [31:0] e0d = '0, e1d = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy0", 32'(busy0), 32'(exp_busy));
      chk("busy1", 32'(busy1), 32'(exp_busy));
      chk("valid0", 32'(val0), 32'(e0v));
      chk("dout0", dout0, e0d);
      chk("valid1", 32'(val1), 32'(e1v));
      chk("dout1", dout1, e1d);
    end
  end

  task automatic idle();
    clear = 1'b0; re = 1'b0; we = 1'b0; wbe = '0;
  endtask

  task automatic model_reset();
    boot = 1'b1; busy_rem = 0; s1v = 1'b0; s1d = '0;
    exp_busy = 1'b0; e0v = 1'b0; e1v = 1'b0;
    e0d = '0; e1d = '0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
  endtask

  // one clock: derive post-edge expectations, then take the edge
  task automatic cycle();
    bit          acc;
    logic [31:0] oldv, merged;
    bit          n0v, n1v, nb;
    logic [31:0] n0d, n1d;
    if (!rst_n) begin
      model_reset();
      @(posedge clk);
      #1;
      return;
    end
    acc    = re && (busy_rem == 0);
    oldv   = mem_m[raddr];
    merged = oldv;
    if (we && busy_rem == 0 && waddr == raddr)
      for (int i = 0; i < 4; i++)
        if (wbe[i]) merged[8*i +: 8] = din[8*i +: 8];
    n0v = acc;
    n0d = acc ? merged : e0d;
    n1v = s1v;
    n1d = s1v ? s1d : e1d;
    s1v = acc;
    s1d = oldv;
    if (busy_rem == 0 && we)
      for (int i = 0; i < 4; i++)
        if (wbe[i]) mem_m[waddr][8*i +: 8] = din[8*i +: 8];
    if (busy_rem > 0) begin
      busy_rem--;
    end else if (boot || clear) begin
      busy_rem = 16;
      for (int a = 0; a < 16; a++) mem_m[a] = '0;
    end
    boot = 1'b0;
    nb   = (busy_rem > 0);
    @(posedge clk);
    e0v = n0v; e0d = n0d;
    e1v = n1v; e1d = n1d;
    exp_busy = nb;
    #1;
  endtask

  task automatic count_busy(output int n);
    n = busy0 ? 1 : 0;
    while (busy0 && n < 40) begin
      idle();
      cycle();
      if (busy0) n++;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be,
                    input logic [31:0] d);
    idle(); we = 1'b1; waddr = a; wbe = be; din = d;
    cycle();
  endtask

  task automatic rd(input logic [3:0] a);
    idle(); re = 1'b1; raddr = a;
    cycle();
  endtask

  initial begin
    int n;
    #2;
    assert_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    cycle();
    chk("rst_dout0", dout0, 32'h0);
    chk("rst_valid0", 32'(val0), 32'h0);
    rst_n = 1'b1;

    // auto clear after reset release
    idle();
    cycle();
    count_busy(n);
    chk("boot_busy_len", 32'(n), 32'd16);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      chk("clr_val", dout0, 32'h0);
      chk("clr_vld", 32'(val0), 32'h1);
    end
    idle();
    cycle();

    // byte merging on write
    wr(4'd3, 4'hF, 32'h11223344);
    wr(4'd3, 4'b0101, 32'hAABBCCDD);
    rd(4'd3);
    chk("merge0", dout0, 32'h11BB33DD);
    idle();
    cycle();
    chk("merge1", dout1, 32'h11BB33DD);

    // read-during-write on the same address
    wr(4'd5, 4'hF, 32'h01020304);
    idle();
    we = 1'b1; waddr = 4'd5; wbe = 4'b1000; din = 32'hFF000000;
    re = 1'b1; raddr = 4'd5;
    cycle();
    chk("rdw_byp", dout0, 32'hFF020304);
    idle();
    cycle();
    chk("rdw_nobyp", dout1, 32'h01020304);
    rd(4'd5);
    chk("rdw_next", dout0, 32'hFF020304);
    idle();
    cycle();

    // two-stage pipeline, back-to-back reads
    wr(4'd0, 4'hF, 32'hA0);
    wr(4'd1, 4'hF, 32'hA1);
    wr(4'd2, 4'hF, 32'hA2);
    rd(4'd0);
    chk("pipe_v0", 32'(val1), 32'h0);
    rd(4'd1);
    chk("pipe_d0", dout1, 32'hA0);
    rd(4'd2);
    chk("pipe_d1", dout1, 32'hA1);
    idle();
    cycle();
    chk("pipe_d2", dout1, 32'hA2);
    chk("pipe_v2", 32'(val1), 32'h1);
    cycle();
    chk("pipe_v3", 32'(val1), 32'h0);

    // clear pulse with a simultaneous write, then a repeated pulse
    wr(4'd7, 4'hF, 32'h77);
    idle();
    clear = 1'b1; we = 1'b1; waddr = 4'd7; wbe = 4'hF; din = 32'h5;
    cycle();
    idle();
    clear = 1'b1;
    cycle();
    n = 2;
    while (busy0 && n < 40) begin
      idle();
      cycle();
      if (busy0) n++;
    end
    chk("clr_busy_len", 32'(n), 32'd16);
    rd(4'd7);
    chk("clr_mem7", dout0, 32'h0);

    // reset in the middle of a clear
    idle();
    clear = 1'b1;
    cycle();
    idle();
    repeat (7) cycle();
    assert_reset();
    #1;
    chk("abort_dout0", dout0, 32'h0);
    chk("abort_busy", 32'(busy0), 32'h0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("rel_valid0", 32'(val0), 32'h0);
    count_busy(n);
    chk("restart_len", 32'(n), 32'd16);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      idle();
      re    = ($urandom_range(0, 2) != 0);
      raddr = 4'($urandom_range(0, 15));
      we    = ($urandom_range(0, 1) != 0);
      waddr = ($urandom_range(0, 3) == 0) ? raddr
                                          : 4'($urandom_range(0, 15));
      wbe   = 4'($urandom_range(0, 15));
      din   = $urandom;
      clear = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 250) == 0) begin
        assert_reset();
        idle();
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end
    idle();
    cycle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
